// File: rtl/axi_sram_rd_slave.sv
// rtl/axi_sram_rd_slave.sv - AXI-lite AR/R responder over a word-addressed array with fixed or LFSR latency
module axi_sram_rd_slave #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h8000_0000,
    parameter int unsigned        DEPTH     = 4096,
    parameter                     INIT_FILE = "",
    parameter bit                 RAND_LAT  = 1'b0,
    parameter int unsigned        FIX_LAT   = 0,
    parameter int unsigned        DLY_W     = 3,
    parameter logic [7:0]         LFSR_SEED = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slv_ar_valid_i,
    input  logic [ADDR_W-1:0] slv_ar_addr_i,
    output logic              slv_ar_ready_o,
    output logic              slv_r_valid_o,
    output logic [DATA_W-1:0] slv_r_data_o,
    output logic [1:0]        slv_r_resp_o,
    input  logic              slv_r_ready_i
);

    localparam int unsigned       IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH) * ADDR_W'(4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d;
    // Low for the first cycle after reset release so AR is never accepted on the release edge.
    logic              live_q, live_d;

    logic [DLY_W-1:0]  delay;
    logic [ADDR_W-1:0] lk_addr;
    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] lk_data;
    logic [1:0]        lk_resp;

    // Decode the address that is about to be answered: the live AR address when a zero-delay
    // handshake goes straight to RESP, otherwise the latched one.
    always_comb begin
        delay   = RAND_LAT ? lfsr_q[DLY_W-1:0] : DLY_W'(FIX_LAT);
        lk_addr = (state_q == S_IDLE) ? slv_ar_addr_i : addr_q;
        off     = lk_addr - BASE_ADDR;
        idx     = off[IDX_W+1:2];
        lk_data = '0;
        lk_resp = RESP_OKAY;
        if (off >= SPAN) begin
            lk_resp = RESP_DECERR;
        end else if (lk_addr[1:0] != 2'b00) begin
            lk_resp = RESP_SLVERR;
        end else begin
            lk_data = mem[idx];
        end
    end

    // Next-state logic: accept AR in IDLE, count down in WAIT, hold the response in RESP.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        live_d   = 1'b1;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        case (state_q)
            S_IDLE: begin
                if (live_q && slv_ar_valid_i) begin
                    addr_d = slv_ar_addr_i;
                    cnt_d  = delay;
                    if (delay == '0) begin
                        state_d  = S_RESP;
                        r_data_d = lk_data;
                        r_resp_d = lk_resp;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - DLY_W'(1);
                if (cnt_q == DLY_W'(1)) begin
                    state_d  = S_RESP;
                    r_data_d = lk_data;
                    r_resp_d = lk_resp;
                end
            end
            S_RESP: begin
                if (slv_r_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any pending request immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            r_data_q <= r_data_d;
            r_resp_q <= r_resp_d;
            live_q   <= live_d;
        end
    end

    assign slv_ar_ready_o = (state_q == S_IDLE) && live_q;
    assign slv_r_valid_o  = (state_q == S_RESP);
    assign slv_r_data_o   = r_data_q;
    assign slv_r_resp_o   = r_resp_q;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// tb/tb_axi_sram_rd_slave.sv - directed and random bench for axi_sram_rd_slave with a timestamp-based model
module tb_axi_sram_rd_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          DEP  = 256;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ar_valid, ar_ready, r_valid, r_ready;
    logic [31:0] ar_addr [3];
    logic [31:0] r_data  [3];
    logic [1:0]  r_resp  [3];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] gm_val(input int k);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'(k);
        b = 16'(k * 7 + 3);
        return (k == 0) ? 32'hDEAD_BEEF : ({a, b} ^ 32'hA5A5_0000);
    endfunction

    function automatic int fix_lat(input int i);
        return (i == 1) ? 3 : 0;
    endfunction

    // u0: FIX_LAT=0, u1: FIX_LAT=3, u2: RAND_LAT=1
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        axi_sram_rd_slave #(
            .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH(DEP), .INIT_FILE(""),
            .RAND_LAT(gi == 2), .FIX_LAT(fix_lat(gi)), .DLY_W(3), .LFSR_SEED(8'hA5)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst_n),
            .slv_ar_valid_i (ar_valid[gi]),
            .slv_ar_addr_i  (ar_addr[gi]),
            .slv_ar_ready_o (ar_ready[gi]),
            .slv_r_valid_o  (r_valid[gi]),
            .slv_r_data_o   (r_data[gi]),
            .slv_r_resp_o   (r_resp[gi]),
            .slv_r_ready_i  (r_ready[gi])
        );
        initial begin
            for (int k = 0; k < DEP; k++) u_dut.mem[k] = gm_val(k);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Model: a request accepted in cycle c answers from cycle c+1+delay until the cycle whose
    // posedge sees r_ready; AR is accepted again from the cycle after that.
    longint      cyc = 0;
    bit          busy [3];
    longint      ready_from [3];
    longint      valid_from [3];
    logic [31:0] ed [3];
    logic [1:0]  er [3];
    logic [7:0]  lm [3];
    int          nreq [3];
    int          nresp [3];
    int          ndrop [3];

    function automatic void golden(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] off;
        off = a - BASE;
        d = 32'h0;
        if (off >= 32'(DEP * 4))  r = 2'b11;
        else if (a[1:0] != 2'b00) r = 2'b10;
        else begin
            r = 2'b00;
            d = gm_val(int'(off >> 2));
        end
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            busy[i] = 0; ready_from[i] = 0; valid_from[i] = 0;
            nreq[i] = 0; nresp[i] = 0; ndrop[i] = 0; lm[i] = 8'hA5;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                int d;
                if (!rst_n) begin
                    if (busy[i]) ndrop[i]++;
                    busy[i] = 0;
                    ready_from[i] = cyc + 2;
                    lm[i] = 8'hA5;
                end else begin
                    if (busy[i] && cyc >= valid_from[i] && r_ready[i]) begin
                        busy[i] = 0;
                        ready_from[i] = cyc + 1;
                        nresp[i]++;
                    end else if (!busy[i] && cyc >= ready_from[i] && ar_valid[i]) begin
                        d = (i == 2) ? int'(lm[i] % 8) : fix_lat(i);
                        chk($sformatf("u%0d lat range", i), 32'((d + 1 >= 1) && (d + 1 <= 8)), 32'd1);
                        valid_from[i] = cyc + 1 + d;
                        golden(ar_addr[i], ed[i], er[i]);
                        busy[i] = 1;
                        nreq[i]++;
                    end
                    lm[i] = {lm[i][6:0], lm[i][7] ^ lm[i][5] ^ lm[i][4] ^ lm[i][3]};
                end
            end
            cyc = cyc + 1;
        end
    end

    // Compare every cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                logic xr, xv;
                xr = rst_n && !busy[i] && (cyc >= ready_from[i]);
                xv = rst_n && busy[i] && (cyc >= valid_from[i]);
                chk($sformatf("u%0d ar_ready c%0d", i, cyc), 32'(ar_ready[i]), 32'(xr));
                chk($sformatf("u%0d r_valid c%0d", i, cyc), 32'(r_valid[i]), 32'(xv));
                if (xv) begin
                    chk($sformatf("u%0d r_data c%0d", i, cyc), r_data[i], ed[i]);
                    chk($sformatf("u%0d r_resp c%0d", i, cyc), 32'(r_resp[i]), 32'(er[i]));
                end
            end
        end
    end

    // One read on instance i; returns observed latency (cycles from AR hs to r_valid).
    task automatic rd(input int i, input logic [31:0] a, input int stall, input bit keep,
                      output int lat, output logic [31:0] d, output logic [1:0] rs);
        int n;
        ar_valid[i] = 1'b1;
        ar_addr[i]  = a;
        r_ready[i]  = (stall == 0);
        n = 0;
        while (!ar_ready[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ar_ready wait", 32'(ar_ready[i]), 32'd1);
        @(negedge clk);
        if (!keep) ar_valid[i] = 1'b0;
        lat = 1;
        while (!r_valid[i] && lat < 40) begin
            chk("ar_ready low in wait", 32'(ar_ready[i]), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("r_valid wait", 32'(r_valid[i]), 32'd1);
        chk("ar_ready low in resp", 32'(ar_ready[i]), 32'd0);
        d  = r_data[i];
        rs = r_resp[i];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall r_valid", 32'(r_valid[i]), 32'd1);
            chk("stall r_data", r_data[i], d);
            chk("stall r_resp", 32'(r_resp[i]), 32'(rs));
            chk("stall ar_ready", 32'(ar_ready[i]), 32'd0);
        end
        r_ready[i] = 1'b1;
        @(negedge clk);
        chk("r_valid after r hs", 32'(r_valid[i]), 32'd0);
        chk("ar_ready after r hs", 32'(ar_ready[i]), 32'd1);
    endtask

    function automatic logic [31:0] rnd_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 5)      return BASE + 32'(4 * $urandom_range(0, DEP - 1));
        else if (sel == 6) return BASE + 32'(4 * $urandom_range(0, DEP - 1) + $urandom_range(1, 3));
        else if (sel == 7) return BASE + 32'(DEP * 4) + 32'(4 * $urandom_range(0, 100));
        else if (sel == 8) return BASE - 32'(4 * $urandom_range(1, 100));
        else               return 32'($urandom);
    endfunction

    initial begin
        int          lat;
        logic [31:0] d;
        logic [1:0]  rs;
        int          base_resp, sent, n;
        bit          hs_next;

        rst_n = 1'b0;
        ar_valid = 3'b000;
        r_ready  = 3'b111;
        for (int i = 0; i < 3; i++) ar_addr[i] = BASE;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // LFSR pin: first accepted AR samples A5 shifted once = 4A -> delay 2 -> latency 3.
        rd(2, BASE + 32'h8, 0, 0, lat, d, rs);
        chk("pin rand first lat", 32'(lat), 32'd3);
        chk("pin rand first data", d, gm_val(2));

        // T1
        rd(0, BASE, 0, 0, lat, d, rs);
        chk("t1 lat", 32'(lat), 32'd1);
        chk("t1 data", d, 32'hDEAD_BEEF);
        chk("t1 resp", 32'(rs), 32'd0);

        // T2: AR held through WAIT, accepted again only after the r hs
        rd(1, BASE + 32'h4, 0, 1, lat, d, rs);
        chk("t2 lat", 32'(lat), 32'd4);
        chk("t2 data", d, gm_val(1));
        rd(1, BASE + 32'h4, 0, 0, lat, d, rs);
        chk("t2 second lat", 32'(lat), 32'd4);
        chk("t2 second count", 32'(nreq[1]), 32'd2);

        // T3
        rd(0, BASE + 32'hC, 5, 0, lat, d, rs);
        chk("t3 data", d, gm_val(3));

        // T4
        rd(0, BASE + 32'h2, 0, 0, lat, d, rs);
        chk("t4 slverr resp", 32'(rs), 32'd2);
        chk("t4 slverr data", d, 32'h0);
        rd(0, BASE + 32'(DEP * 4), 0, 0, lat, d, rs);
        chk("t4 decerr top resp", 32'(rs), 32'd3);
        chk("t4 decerr top data", d, 32'h0);
        rd(0, 32'h7FFF_FFFC, 0, 0, lat, d, rs);
        chk("t4 decerr wrap resp", 32'(rs), 32'd3);
        rd(0, BASE + 32'(DEP * 4 - 4), 0, 0, lat, d, rs);
        chk("t4 last word resp", 32'(rs), 32'd0);
        chk("t4 last word data", d, gm_val(DEP - 1));

        // T5: u0 parked in RESP, u1 in WAIT, then reset
        ar_valid[0] = 1'b1; ar_addr[0] = BASE; r_ready[0] = 1'b0;
        ar_valid[1] = 1'b1; ar_addr[1] = BASE;
        @(negedge clk);
        ar_valid[0] = 1'b0;
        ar_valid[1] = 1'b0;
        chk("t5 u0 in resp", 32'(r_valid[0]), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 u0 r_valid async drop", 32'(r_valid[0]), 32'd0);
        chk("t5 u1 r_valid", 32'(r_valid[1]), 32'd0);
        chk("t5 u1 ar_ready in reset", 32'(ar_ready[1]), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        r_ready[0] = 1'b1;
        #1 chk("t5 ar_ready at release", 32'(ar_ready[1]), 32'd0);
        rd(1, BASE, 0, 0, lat, d, rs);
        chk("t5 lat", 32'(lat), 32'd4);
        chk("t5 data", d, 32'hDEAD_BEEF);

        // T6: random traffic on u2
        @(negedge clk);
        base_resp = nresp[2];
        sent = 0;
        hs_next = 0;
        n = 0;
        while (nresp[2] < base_resp + 1000 && n < 40000) begin
            if (hs_next || !ar_valid[2]) begin
                if (sent < 1000 && $urandom_range(0, 2) != 0) begin
                    ar_valid[2] = 1'b1;
                    ar_addr[2]  = rnd_addr();
                    sent++;
                end else begin
                    ar_valid[2] = 1'b0;
                end
            end
            hs_next    = ar_valid[2] && ar_ready[2];
            r_ready[2] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        ar_valid[2] = 1'b0;
        r_ready[2]  = 1'b1;
        chk("t6 responses", 32'(nresp[2] - base_resp), 32'd1000);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("u%0d req accounted", i), 32'(nreq[i]), 32'(nresp[i] + ndrop[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
